// File: rtl/mhq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mhq_ctrl
// Description : Miss-handling queue. CAM-merges missed loads/stores per line,
//               fetches lines in FIFO order and emits merged fills.
//               Option macro: MHQ_FILL_MERGE_EN (merge stores into the fill
//               of the head entry during its done cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module mhq_ctrl #(
    parameter int MHQ_DEPTH  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_SIZE  = 32
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          i_enq_en,
    input  logic                          i_enq_we,
    input  logic [ADDR_WIDTH-1:0]         i_enq_addr,
    input  logic [DATA_WIDTH-1:0]         i_enq_data,
    input  logic [DATA_WIDTH/8-1:0]       i_enq_byte_sel,
    output logic                          o_enq_ack,
    output logic                          o_full,
    output logic                          o_ccu_req_valid,
    input  logic                          i_ccu_req_ready,
    output logic [ADDR_WIDTH-1:0]         o_ccu_req_addr,
    input  logic                          i_ccu_done,
    input  logic [8*LINE_SIZE-1:0]        i_ccu_data,
    output logic                          o_fill_en,
    output logic [$clog2(MHQ_DEPTH)-1:0]  o_fill_tag,
    output logic                          o_fill_dirty,
    output logic [ADDR_WIDTH-1:0]         o_fill_addr,
    output logic [8*LINE_SIZE-1:0]        o_fill_data
);

    localparam int OFS_W  = $clog2(LINE_SIZE);
    localparam int TAG_W  = $clog2(MHQ_DEPTH);
    localparam int LINE_W = 8 * LINE_SIZE;
    localparam int LA_W   = ADDR_WIDTH - OFS_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [MHQ_DEPTH-1:0]   r_valid, w_valid_nxt;
    logic [MHQ_DEPTH-1:0]   r_dirty;
    logic [LA_W-1:0]        r_laddr [MHQ_DEPTH];
    logic [LINE_W-1:0]      r_data  [MHQ_DEPTH];
    logic [LINE_SIZE-1:0]   r_upd   [MHQ_DEPTH];
    logic [TAG_W-1:0]       r_head, r_tail;

    logic                   r_full, r_req_valid, r_fill_en, r_fill_dirty;
    logic [ADDR_WIDTH-1:0]  r_req_addr, r_fill_addr;
    logic [TAG_W-1:0]       r_fill_tag;
    logic [LINE_W-1:0]      r_fill_data;

    logic [LA_W-1:0]        w_enq_laddr;
    logic [OFS_W-1:0]       w_enq_ofs;
    logic [LINE_SIZE-1:0]   w_st_mask;
    logic [LINE_W-1:0]      w_st_line, w_st_bits, w_upd_bits, w_fill_line, w_fill_data;
    logic                   w_hit, w_hit_ok, w_pop, w_hit_head_pop, w_full_now;
    logic                   w_alloc, w_merge, w_fill_st;
    logic [TAG_W-1:0]       w_hit_idx;

    function automatic logic [LINE_W-1:0] f_expand(input logic [LINE_SIZE-1:0] m);
        logic [LINE_W-1:0] v;
        for (int b = 0; b < LINE_SIZE; b++) v[b*8 +: 8] = {8{m[b]}};
        return v;
    endfunction

    // Store bytes placed at their line offset; anything past the line end shifts out.
    assign w_enq_laddr = i_enq_addr[ADDR_WIDTH-1:OFS_W];
    assign w_enq_ofs   = i_enq_addr[OFS_W-1:0];
    assign w_st_mask   = LINE_SIZE'(i_enq_byte_sel) << w_enq_ofs;
    assign w_st_line   = LINE_W'(i_enq_data) << {w_enq_ofs, 3'b000};
    assign w_st_bits   = f_expand(w_st_mask);

    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < MHQ_DEPTH; i++) begin
            if (r_valid[i] && (r_laddr[i] == w_enq_laddr)) begin
                w_hit     = 1'b1;
                w_hit_idx = TAG_W'(i);
            end
        end
    end

    assign w_pop          = (r_state == ST_WAIT) && i_ccu_done;
    assign w_hit_head_pop = w_pop && w_hit && (w_hit_idx == r_head);
    assign w_full_now     = &r_valid;

`ifdef MHQ_FILL_MERGE_EN
    assign w_hit_ok  = w_hit;
    assign w_fill_st = i_enq_en && i_enq_we && w_hit_head_pop;
`else
    assign w_hit_ok  = w_hit && !w_hit_head_pop;
    assign w_fill_st = 1'b0;
`endif

    assign o_enq_ack = i_enq_en && (w_hit ? w_hit_ok : !w_full_now);
    assign w_alloc   = i_enq_en && !w_hit && !w_full_now;
    assign w_merge   = i_enq_en && i_enq_we && w_hit && !w_hit_head_pop;

    always_comb begin
        w_valid_nxt = r_valid;
        if (w_alloc) w_valid_nxt[r_tail] = 1'b1;
        if (w_pop)   w_valid_nxt[r_head] = 1'b0;
    end

    // Fill byte priority: same-cycle store, then previously merged byte, then CCU.
    assign w_upd_bits  = f_expand(r_upd[r_head]);
    assign w_fill_line = (i_ccu_data & ~w_upd_bits) | (r_data[r_head] & w_upd_bits);
    assign w_fill_data = w_fill_st ? ((w_fill_line & ~w_st_bits) | (w_st_line & w_st_bits))
                                   : w_fill_line;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_valid[r_head])  w_state_nxt = ST_REQ;
            ST_REQ:  if (i_ccu_req_ready)  w_state_nxt = ST_WAIT;
            ST_WAIT: if (i_ccu_done)       w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= ST_IDLE;
            r_valid      <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_full       <= 1'b0;
            r_req_valid  <= 1'b0;
            r_req_addr   <= '0;
            r_fill_en    <= 1'b0;
            r_fill_tag   <= '0;
            r_fill_dirty <= 1'b0;
            r_fill_addr  <= '0;
            r_fill_data  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_valid   <= w_valid_nxt;
            r_full    <= &w_valid_nxt;
            r_fill_en <= w_pop;
            if (w_alloc) r_tail <= r_tail + TAG_W'(1);
            if (w_pop)   r_head <= r_head + TAG_W'(1);
            if ((r_state == ST_IDLE) && r_valid[r_head]) begin
                r_req_valid <= 1'b1;
                r_req_addr  <= {r_laddr[r_head], {OFS_W{1'b0}}};
            end else if ((r_state == ST_REQ) && i_ccu_req_ready) begin
                r_req_valid <= 1'b0;
            end
            if (w_pop) begin
                r_fill_tag   <= r_head;
                r_fill_dirty <= r_dirty[r_head] | w_fill_st;
                r_fill_addr  <= {r_laddr[r_head], {OFS_W{1'b0}}};
                r_fill_data  <= w_fill_data;
            end
        end
    end

    // Entry payload is qualified by r_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_laddr[r_tail] <= w_enq_laddr;
            r_data[r_tail]  <= w_st_line;
            r_upd[r_tail]   <= i_enq_we ? w_st_mask : '0;
            r_dirty[r_tail] <= i_enq_we;
        end
        if (w_merge) begin
            r_data[w_hit_idx]  <= (r_data[w_hit_idx] & ~w_st_bits) | (w_st_line & w_st_bits);
            r_upd[w_hit_idx]   <= r_upd[w_hit_idx] | w_st_mask;
            r_dirty[w_hit_idx] <= 1'b1;
        end
    end

    assign o_full          = r_full;
    assign o_ccu_req_valid = r_req_valid;
    assign o_ccu_req_addr  = r_req_addr;
    assign o_fill_en       = r_fill_en;
    assign o_fill_tag      = r_fill_tag;
    assign o_fill_dirty    = r_fill_dirty;
    assign o_fill_addr     = r_fill_addr;
    assign o_fill_data     = r_fill_data;

endmodule
`default_nettype wire
